// File: rtl/mem_pkg.sv
// Shared definitions for the 16 x 32-bit register-file memory.
package mem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] RESET_WORD = '0;

    // Encoding of the W_R select line.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Storage array with a single synchronous write port, combinational read
// of the addressed word, and asynchronous clear of every word.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];

    // Word storage: async clear to the reset word, write on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: DATA_W'(RESET_WORD)};
        end else if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Addressed word, consumed by the output register stage on reads.
    always_comb begin
        rd_data = mem[addr];
    end

endmodule : mem_array

// File: rtl/memory_modport.sv
// Single-port 16 x 32 memory with a registered, valid-qualified read port.
// Port names match the signal set of the verification interface's modport.
module memory_modport
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              W_R,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_In,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Valid_Out
);

    op_e               op;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    // Decode the enabled operation for this edge.
    always_comb begin
        op    = op_e'(W_R);
        wr_en = EN && (op == OP_WRITE);
        rd_en = EN && (op == OP_READ);
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (wr_en),
        .addr    (Address),
        .wr_data (Data_In),
        .rd_data (rd_word)
    );

    // Output stage: reads load data and pulse valid; writes and idle hold data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Data_Out  <= DATA_W'(RESET_WORD);
            Valid_Out <= 1'b0;
        end else begin
            Valid_Out <= rd_en;
            if (rd_en) begin
                Data_Out <= rd_word;
            end
        end
    end

endmodule : memory_modport

// File: tb/tb_memory_modport.sv
// Directed and randomized checks of memory_modport against an array model.
module tb_memory_modport;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        W_R;
    logic [3:0]  Address;
    logic [31:0] Data_In;
    logic [31:0] Data_Out;
    logic        Valid_Out;

    int unsigned checks;
    int unsigned errors;

    logic [31:0] ref_mem [16];
    logic [31:0] exp_data;
    logic        exp_valid;

    memory_modport #(
        .ADDR_W (4),
        .DATA_W (32)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .W_R       (W_R),
        .Address   (Address),
        .Data_In   (Data_In),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"}, Data_Out, exp_data);
        check({tag, ".valid"}, {31'd0, Valid_Out}, {31'd0, exp_valid});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        exp_data  = 32'h0;
        exp_valid = 1'b0;
    endtask

    // Called at a falling edge: drive, let the rising edge sample, check at next falling edge.
    task automatic do_op(input string tag, input logic en, input logic wr,
                         input logic [3:0] a, input logic [31:0] d);
        EN      = en;
        W_R     = wr;
        Address = a;
        Data_In = d;
        @(posedge CLK);
        if (en === 1'b1) begin
            if (wr) begin
                ref_mem[a] = d;
                exp_valid  = 1'b0;
            end else begin
                exp_data  = ref_mem[a];
                exp_valid = 1'b1;
            end
        end else begin
            exp_valid = 1'b0;
        end
        @(negedge CLK);
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse placed between edges; released at a falling edge.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b0;
        #1;
        model_clear();
        check_outputs({tag, ".during"});
        @(negedge CLK);
        check_outputs({tag, ".held"});
        RST = 1'b1;
    endtask

    initial begin
        logic        r_en;
        logic        r_wr;
        logic [3:0]  r_a;
        logic [31:0] r_d;

        checks = 0;
        errors = 0;
        model_clear();
        RST     = 1'b0;
        EN      = 1'b0;
        W_R     = 1'b0;
        Address = '0;
        Data_In = '0;

        // Power-on reset state
        #1;
        check_outputs("por");
        @(negedge CLK);
        @(negedge CLK);
        check_outputs("por_held");
        RST = 1'b1;

        // Write/read round trip
        do_op("wr3", 1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
        do_op("rd3", 1'b1, 1'b0, 4'd3, 32'h0);
        check("rd3.literal", Data_Out, 32'hDEADBEEF);

        // Full sweep: write all, then back-to-back reads
        for (int i = 0; i < 16; i++)
            do_op("sweep_wr", 1'b1, 1'b1, 4'(i), 32'(i) * 32'h11111111);
        for (int i = 0; i < 16; i++)
            do_op("sweep_rd", 1'b1, 1'b0, 4'(i), 32'h0);
        check("sweep_last", Data_Out, 32'hFFFFFFFF);

        // Enable gating: disabled write must not land
        do_op("gate_off", 1'b0, 1'b1, 4'd7, 32'h12345678);
        do_op("gate_rd7", 1'b1, 1'b0, 4'd7, 32'h0);
        check("gate_rd7.literal", Data_Out, 32'h77777777);
        do_op("gate_x", 1'b0, 1'bx, 4'bxxxx, 32'hxxxxxxxx);

        // Write after read keeps Data_Out, drops Valid_Out
        do_op("wa_wr2", 1'b1, 1'b1, 4'd2, 32'hA5A5A5A5);
        do_op("wa_rd2", 1'b1, 1'b0, 4'd2, 32'h0);
        do_op("wa_wr2z", 1'b1, 1'b1, 4'd2, 32'h0);
        check("wa_hold.literal", Data_Out, 32'hA5A5A5A5);
        do_op("wa_rd2z", 1'b1, 1'b0, 4'd2, 32'h0);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            r_en = ($urandom_range(0, 3) != 0);
            r_wr = 1'($urandom_range(0, 1));
            r_a  = 4'($urandom_range(0, 15));
            r_d  = $urandom;
            if (r_en)
                do_op("rand", 1'b1, r_wr, r_a, r_d);
            else
                do_op("rand_idle", 1'b0, 1'bx, 4'bxxxx, 32'hxxxxxxxx);
        end

        // Mid-simulation reset, then read address 5
        async_reset("rst_mid");
        do_op("rst_rd5", 1'b1, 1'b0, 4'd5, 32'h0);
        check("rst_rd5.valid1", {31'd0, Valid_Out}, 32'd1);

        // Async reset during a read burst
        for (int i = 0; i < 16; i++)
            do_op("burst_wr", 1'b1, 1'b1, 4'(i), ~(32'(i) * 32'h01010101));
        do_op("burst_rd0", 1'b1, 1'b0, 4'd0, 32'h0);
        do_op("burst_rd1", 1'b1, 1'b0, 4'd1, 32'h0);
        EN      = 1'b1;
        W_R     = 1'b0;
        Address = 4'd2;
        @(posedge CLK);
        exp_data  = ref_mem[2];
        exp_valid = 1'b1;
        #1;
        check_outputs("burst_rd2");
        async_reset("burst_rst");
        for (int i = 0; i < 16; i++)
            do_op("post_rst_rd", 1'b1, 1'b0, 4'(i), 32'h0);
        do_op("tail_idle", 1'b0, 1'b0, 4'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_memory_modport
